accumulator_addsub_sat_nbit: RTL

//  N-bit running accumulator with per-operand add/sub and signed/unsigned mode.

---
 rtl/accumulator_addsub_sat_nbit_pkg.sv | 13 +
 rtl/accumulator_addsub_sat_nbit_addsub.sv | 52 +++++
 rtl/accumulator_addsub_sat_nbit.sv | 91 +++++++++
 3 files changed

// File: rtl/accumulator_addsub_sat_nbit_pkg.sv
// Shared opcode and mode encodings for the add/sub saturating accumulator.
package accumulator_addsub_sat_nbit_pkg;

    localparam logic OP_ADD        = 1'b0;
    localparam logic OP_SUB        = 1'b1;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam logic MODE_WRAP     = 1'b0;
    localparam logic MODE_SAT      = 1'b1;

endpackage

// File: rtl/accumulator_addsub_sat_nbit_addsub.sv
// Combinational N-bit add/sub with overflow detection and optional clamping.
// Works on N+1 bits so the top bit doubles as unsigned carry/borrow.
module addsub_sat_nbit
    import accumulator_addsub_sat_nbit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] a,
    input  logic         sub,
    input  logic         is_signed,
    input  logic         sat,
    output logic [N-1:0] res,
    output logic         ovf
);

    // Clamp value on overflow: unsigned pins to the rail in the direction of
    // travel; signed pins to the rail matching the accumulator's sign.
    function automatic logic [N-1:0] sat_value(input logic sgn, input logic is_sub,
                                               input logic acc_msb);
        logic [N-1:0] v;
        if (sgn == MODE_SIGNED)
            v = acc_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            v = (is_sub == OP_SUB) ? {N{1'b0}} : {N{1'b1}};
        return v;
    endfunction

    logic [N:0]   sum_ext;
    logic [N-1:0] wrap_res;
    logic         ovf_u;
    logic         ovf_s;

    // Raw sum/difference, overflow classification and output selection.
    always_comb begin
        sum_ext  = (sub == OP_SUB) ? ({1'b0, acc} - {1'b0, a})
                                   : ({1'b0, acc} + {1'b0, a});
        wrap_res = sum_ext[N-1:0];
        // Bit N is carry-out on add and borrow (acc < a) on sub.
        ovf_u    = sum_ext[N];
        if (sub == OP_SUB)
            ovf_s = (acc[N-1] != a[N-1]) && (wrap_res[N-1] != acc[N-1]);
        else
            ovf_s = (acc[N-1] == a[N-1]) && (wrap_res[N-1] != acc[N-1]);
        ovf = (is_signed == MODE_SIGNED) ? ovf_s : ovf_u;
        if (sat == MODE_SAT && ovf)
            res = sat_value(is_signed, sub, acc[N-1]);
        else
            res = wrap_res;
    end

endmodule

// File: rtl/accumulator_addsub_sat_nbit.sv
// Two-stage running accumulator: input register stage, then accumulate stage
// with per-op overflow, sticky overflow and a saturating op counter.
module accumulator_addsub_sat_nbit
    import accumulator_addsub_sat_nbit_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [N-1:0]     i_A,
    input  logic             i_addsub,
    input  logic             i_signed,
    input  logic             i_sat,
    input  logic             i_clr,
    output logic [N-1:0]     o_S,
    output logic             o_valid,
    output logic             o_overflow,
    output logic             o_ovf_stky,
    output logic [CNT_W-1:0] o_count
);

    logic [N-1:0] a_p1;
    logic         sub_p1;
    logic         sgn_p1;
    logic         sat_p1;
    logic         vld_p1;

    logic [N-1:0] res_p1;
    logic         ovf_p1;

    // Stage 1: operand and mode bits registered together so mode changes
    // only affect ops launched after the change.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_p1   <= '0;
            sub_p1 <= OP_ADD;
            sgn_p1 <= MODE_UNSIGNED;
            sat_p1 <= MODE_WRAP;
            vld_p1 <= 1'b0;
        end else if (i_clr) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                a_p1   <= i_A;
                sub_p1 <= i_addsub;
                sgn_p1 <= i_signed;
                sat_p1 <= i_sat;
            end
        end
    end

    addsub_sat_nbit #(.N(N)) u_addsub (
        .acc       (o_S),
        .a         (a_p1),
        .sub       (sub_p1),
        .is_signed (sgn_p1),
        .sat       (sat_p1),
        .res       (res_p1),
        .ovf       (ovf_p1)
    );

    // Stage 2: accumulate, update flags and count accepted ops.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_S        <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_ovf_stky <= 1'b0;
            o_count    <= '0;
        end else if (i_clr) begin
            o_S        <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_ovf_stky <= 1'b0;
            o_count    <= '0;
        end else if (vld_p1) begin
            o_S        <= res_p1;
            o_valid    <= 1'b1;
            o_overflow <= ovf_p1;
            o_ovf_stky <= o_ovf_stky | ovf_p1;
            if (o_count != {CNT_W{1'b1}})
                o_count <= o_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            o_valid    <= 1'b0;
        end
    end

endmodule
